// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell with a registered carry, LSB first.
// Captures a/b on start, reports sum/cout with a one-cycle done pulse after WIDTH bit cycles.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// ADD   | one operand bit per clock through the full adder
// DONE  | result valid, done high for this single cycle
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic             c;
    logic             s;
    logic             c_nxt;
    logic [CW-1:0]    cnt;

    // Written as shift-then-insert so WIDTH=1 needs no special slicing.
    always_comb begin
        s                = a_sr[0] ^ b_sr[0] ^ c;
        c_nxt            = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
        sum_nxt          = sum_sr >> 1;
        sum_nxt[WIDTH-1] = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            c      <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c     <= 1'b0;
                        cnt   <= '0;
                        state <= ADD;
                        busy  <= 1'b1;
                    end
                end
                ADD: begin
                    sum_sr <= sum_nxt;
                    c      <= c_nxt;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = sum_sr;
    assign cout = c;

endmodule
